// File: rtl/fight_meter.sv
// fight_meter: attack-timing meter for the FIGHT phase.
// A bar sweeps across the fight box. A player hit latches its position and
// scores it by distance from the box centre. The bar then blinks, and o_done
// pulses. A registered pixel layer (frame, zone columns, bar) feeds the VGA mixer.
// Optional build macro: FIGHT_METER_BOUNCE_EN. When defined, the bar makes one
// return pass from the right limit instead of missing there.
`timescale 1ns/1ps
module fight_meter #(
    parameter int FX           = 100,
    parameter int FY           = 230,
    parameter int F_WIDTH      = 440,
    parameter int F_HEIGHT     = 150,
    parameter int BORDER       = 5,
    parameter int BAR_R        = 2,
    parameter int VELOCITY     = 10,
    parameter int NUM_ZONES    = 4,
    parameter int ZONE_STEP    = 50,
    parameter int ZONE_TAPER   = 20,
    parameter int FLASH_FRAMES = 30
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic        i_start,
    input  logic        i_hit,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_score,
    output logic [3:0]  o_zone,
    output logic [15:0] o_bar_x,
    output logic        o_pix_en,
    output logic [3:0]  o_red,
    output logic [3:0]  o_green,
    output logic [3:0]  o_blue
);
    localparam logic [15:0] CX         = 16'(FX + F_WIDTH / 2);
    localparam logic [15:0] X_MIN      = 16'(FX + BAR_R);
    localparam logic [16:0] X_MAX      = 17'(FX + F_WIDTH - BAR_R);
    localparam logic [16:0] VEL        = 17'(VELOCITY);
    localparam logic [15:0] BAR_HW     = 16'(BAR_R);
    localparam logic [15:0] IX_L       = 16'(FX);
    localparam logic [15:0] IX_R       = 16'(FX + F_WIDTH);
    localparam logic [15:0] IY_T       = 16'(FY);
    localparam logic [15:0] IY_B       = 16'(FY + F_HEIGHT);
    localparam logic [15:0] OX_L       = 16'(FX - BORDER);
    localparam logic [15:0] OX_R       = 16'(FX + F_WIDTH + BORDER);
    localparam logic [15:0] OY_T       = 16'(FY - BORDER);
    localparam logic [15:0] OY_B       = 16'(FY + F_HEIGHT + BORDER);
    localparam logic [3:0]  ZONE_MISS  = 4'(NUM_ZONES);
    localparam logic [7:0]  FLASH_LAST = 8'(FLASH_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_FLASH = 2'd2
    } state_t;

    // Unsigned distance without wrap: larger operand always minuend.
    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        if (a >= b) abs_diff = a - b;
        else        abs_diff = b - a;
    endfunction

    // Smallest zone k with d <= (k+1)*ZONE_STEP; NUM_ZONES when outside all.
    function automatic logic [3:0] zone_of(input logic [15:0] d);
        zone_of = ZONE_MISS;
        for (int k = NUM_ZONES - 1; k >= 0; k--) begin
            if (d <= 16'((k + 1) * ZONE_STEP)) zone_of = 4'(k);
        end
    endfunction

    state_t      r_state, w_state_nxt;
    logic [15:0] r_bar_x, w_bar_x_nxt;
    logic [7:0]  r_score, w_score_nxt;
    logic [3:0]  r_zone, w_zone_nxt;
    logic [7:0]  r_flash_cnt, w_flash_cnt_nxt;
    logic        r_busy, r_done, w_done_nxt;
    logic        r_pix_en, w_pix_en;
    logic [3:0]  r_red, r_green, r_blue, w_red, w_green, w_blue;
`ifdef FIGHT_METER_BOUNCE_EN
    logic        r_dir_left, w_dir_left_nxt;
`endif

    logic        w_tick;
    logic [3:0]  w_hit_zone;
    logic [7:0]  w_hit_score;
    logic        w_bar_vis;
    logic [3:0]  w_pix_zone;
    logic [15:0] w_inset;

    assign w_tick      = i_ani_stb & i_animate;
    assign w_hit_zone  = zone_of(abs_diff(r_bar_x, CX));
    assign w_hit_score = (w_hit_zone == ZONE_MISS) ? 8'd0 : (8'(NUM_ZONES) - {4'd0, w_hit_zone});
    assign w_bar_vis   = (r_state == ST_SWEEP) || ((r_state == ST_FLASH) && !r_flash_cnt[2]);
    assign w_pix_zone  = zone_of(abs_diff(i_x, CX));
    assign w_inset     = 16'(w_pix_zone) * 16'(ZONE_TAPER);

    // Next-state, bar motion, hit scoring and flash timing.
    always_comb begin
        w_state_nxt     = r_state;
        w_bar_x_nxt     = r_bar_x;
        w_score_nxt     = r_score;
        w_zone_nxt      = r_zone;
        w_flash_cnt_nxt = r_flash_cnt;
        w_done_nxt      = 1'b0;
`ifdef FIGHT_METER_BOUNCE_EN
        w_dir_left_nxt  = r_dir_left;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt     = ST_SWEEP;
                    w_bar_x_nxt     = X_MIN;
                    w_score_nxt     = 8'd0;
                    w_zone_nxt      = ZONE_MISS;
                    w_flash_cnt_nxt = 8'd0;
`ifdef FIGHT_METER_BOUNCE_EN
                    w_dir_left_nxt  = 1'b0;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (i_hit) begin
                    // Hit takes priority over a coincident advance or miss.
                    w_state_nxt     = ST_FLASH;
                    w_score_nxt     = w_hit_score;
                    w_zone_nxt      = w_hit_zone;
                    w_flash_cnt_nxt = 8'd0;
                end else if (w_tick) begin
`ifdef FIGHT_METER_BOUNCE_EN
                    if (!r_dir_left) begin
                        if (({1'b0, r_bar_x} + VEL) > X_MAX) w_dir_left_nxt = 1'b1;
                        else                                 w_bar_x_nxt = r_bar_x + VEL[15:0];
                    end else if ({1'b0, r_bar_x} < ({1'b0, X_MIN} + VEL)) begin
                        w_state_nxt     = ST_FLASH;
                        w_score_nxt     = 8'd0;
                        w_zone_nxt      = ZONE_MISS;
                        w_flash_cnt_nxt = 8'd0;
                    end else begin
                        w_bar_x_nxt = r_bar_x - VEL[15:0];
                    end
`else
                    if (({1'b0, r_bar_x} + VEL) > X_MAX) begin
                        w_state_nxt     = ST_FLASH;
                        w_score_nxt     = 8'd0;
                        w_zone_nxt      = ZONE_MISS;
                        w_flash_cnt_nxt = 8'd0;
                    end else begin
                        w_bar_x_nxt = r_bar_x + VEL[15:0];
                    end
`endif
                end else begin
                    w_state_nxt = ST_SWEEP;
                end
            end
            ST_FLASH: begin
                if (w_tick) begin
                    if (r_flash_cnt == FLASH_LAST) begin
                        w_state_nxt     = ST_IDLE;
                        w_done_nxt      = 1'b1;
                        w_flash_cnt_nxt = 8'd0;
                    end else begin
                        w_flash_cnt_nxt = r_flash_cnt + 8'd1;
                    end
                end else begin
                    w_state_nxt = ST_FLASH;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_flash_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Pixel priority: bar over frame over zone columns.
    always_comb begin
        w_pix_en = 1'b0;
        w_red    = 4'h0;
        w_green  = 4'h0;
        w_blue   = 4'h0;
        if (w_bar_vis && (abs_diff(i_x, r_bar_x) <= BAR_HW) && (i_y >= IY_T) && (i_y <= IY_B)) begin
            w_pix_en = 1'b1; w_red = 4'hF; w_green = 4'hF; w_blue = 4'hF;
        end else if ((i_x >= OX_L) && (i_x <= OX_R) && (i_y >= OY_T) && (i_y <= OY_B) &&
                     !((i_x >= IX_L) && (i_x <= IX_R) && (i_y >= IY_T) && (i_y <= IY_B))) begin
            w_pix_en = 1'b1; w_red = 4'hF; w_green = 4'hF; w_blue = 4'hF;
        end else if ((w_pix_zone != ZONE_MISS) && (i_y >= (IY_T + w_inset)) && ((i_y + w_inset) <= IY_B)) begin
            w_pix_en = 1'b1;
            case (w_pix_zone)
                4'd0:    begin w_red = 4'h0; w_green = 4'hF; w_blue = 4'h0; end
                4'd1:    begin w_red = 4'hF; w_green = 4'hF; w_blue = 4'h0; end
                4'd2:    begin w_red = 4'hF; w_green = 4'hA; w_blue = 4'h0; end
                default: begin w_red = 4'h8; w_green = 4'hC; w_blue = 4'hF; end
            endcase
        end else begin
            w_pix_en = 1'b0;
        end
    end

    // State, meter results and pixel layer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_bar_x     <= X_MIN;
            r_score     <= 8'd0;
            r_zone      <= ZONE_MISS;
            r_flash_cnt <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pix_en    <= 1'b0;
            r_red       <= 4'h0;
            r_green     <= 4'h0;
            r_blue      <= 4'h0;
`ifdef FIGHT_METER_BOUNCE_EN
            r_dir_left  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_bar_x     <= w_bar_x_nxt;
            r_score     <= w_score_nxt;
            r_zone      <= w_zone_nxt;
            r_flash_cnt <= w_flash_cnt_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
            r_pix_en    <= w_pix_en;
            r_red       <= w_red;
            r_green     <= w_green;
            r_blue      <= w_blue;
`ifdef FIGHT_METER_BOUNCE_EN
            r_dir_left  <= w_dir_left_nxt;
`endif
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_score  = r_score;
    assign o_zone   = r_zone;
    assign o_bar_x  = r_bar_x;
    assign o_pix_en = r_pix_en;
    assign o_red    = r_red;
    assign o_green  = r_green;
    assign o_blue   = r_blue;
endmodule

// File: tb/tb_fight_meter.sv
// tb_fight_meter: two meter instances (VELOCITY 10 and 4) driven by the same
// stimulus, each compared every cycle against an arithmetic model of the meter.
`timescale 1ns/1ps
module tb_fight_meter;
    localparam int FX = 100, FY = 230, F_WIDTH = 440, F_HEIGHT = 150, BORDER = 5;
    localparam int BAR_R = 2, NUM_ZONES = 4, ZONE_STEP = 50, ZONE_TAPER = 20;
    localparam int FLASH_FRAMES = 30, CX = FX + F_WIDTH / 2;

    logic        clk = 1'b0, rst_n = 1'b0, ani_stb = 1'b0, animate = 1'b0;
    logic        start = 1'b0, hit = 1'b0;
    logic [15:0] ix = 16'd0, iy = 16'd0;

    logic        busy_a, done_a, pix_a, busy_b, done_b, pix_b;
    logic [7:0]  score_a, score_b;
    logic [3:0]  zone_a, zone_b, r_a, g_a, b_a, r_b, g_b, b_b;
    logic [15:0] bx_a, bx_b;

    int n_tests = 0, n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fight_meter u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani_stb), .i_animate(animate),
        .i_start(start), .i_hit(hit), .i_x(ix), .i_y(iy),
        .o_busy(busy_a), .o_done(done_a), .o_score(score_a), .o_zone(zone_a),
        .o_bar_x(bx_a), .o_pix_en(pix_a), .o_red(r_a), .o_green(g_a), .o_blue(b_a));

    fight_meter #(.VELOCITY(4)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani_stb), .i_animate(animate),
        .i_start(start), .i_hit(hit), .i_x(ix), .i_y(iy),
        .o_busy(busy_b), .o_done(done_b), .o_score(score_b), .o_zone(zone_b),
        .o_bar_x(bx_b), .o_pix_en(pix_b), .o_red(r_b), .o_green(g_b), .o_blue(b_b));

    // phase: 0 idle, 1 sweeping, 2 flashing
    typedef struct packed {
        int phase; int x; int flash; int score; int zone;
        int busy; int done; int pix; int r; int g; int b;
    } mdl_t;

    mdl_t m_a, m_b;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int zone_of(input int d);
        int z;
        z = (d == 0) ? 0 : (d - 1) / ZONE_STEP;
        return (z >= NUM_ZONES) ? NUM_ZONES : z;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m = '0;
        m.x = FX + BAR_R;
        m.zone = NUM_ZONES;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int vel, input bit st, input bit ht,
                                      input bit tk, input int px, input int py);
        mdl_t n;
        bit vis, in_box, in_outer;
        int k;
        int zr[4] = '{0, 15, 15, 8};
        int zg[4] = '{15, 15, 10, 12};
        int zb[4] = '{0, 0, 0, 15};
        n = m;
        n.done = 0;
        vis = (m.phase == 1) || (m.phase == 2 && ((m.flash / 4) % 2 == 0));
        in_box = px >= FX && px <= FX + F_WIDTH && py >= FY && py <= FY + F_HEIGHT;
        in_outer = px >= FX - BORDER && px <= FX + F_WIDTH + BORDER &&
                   py >= FY - BORDER && py <= FY + F_HEIGHT + BORDER;
        k = zone_of(iabs(px - CX));
        if (vis && iabs(px - m.x) <= BAR_R && py >= FY && py <= FY + F_HEIGHT) begin
            n.pix = 1; n.r = 15; n.g = 15; n.b = 15;
        end else if (in_outer && !in_box) begin
            n.pix = 1; n.r = 15; n.g = 15; n.b = 15;
        end else if (k < NUM_ZONES && py >= FY + k * ZONE_TAPER && py <= FY + F_HEIGHT - k * ZONE_TAPER) begin
            n.pix = 1; n.r = zr[k > 3 ? 3 : k]; n.g = zg[k > 3 ? 3 : k]; n.b = zb[k > 3 ? 3 : k];
        end else begin
            n.pix = 0; n.r = 0; n.g = 0; n.b = 0;
        end
        if (m.phase == 0) begin
            if (st) begin
                n.phase = 1; n.x = FX + BAR_R; n.score = 0; n.zone = NUM_ZONES; n.flash = 0;
            end
        end else if (m.phase == 1) begin
            if (ht) begin
                n.zone = zone_of(iabs(m.x - CX));
                n.score = (n.zone == NUM_ZONES) ? 0 : NUM_ZONES - n.zone;
                n.phase = 2; n.flash = 0;
            end else if (tk) begin
                if (m.x + vel > FX + F_WIDTH - BAR_R) begin
                    n.score = 0; n.zone = NUM_ZONES; n.phase = 2; n.flash = 0;
                end else begin
                    n.x = m.x + vel;
                end
            end
        end else begin
            if (tk) begin
                if (m.flash + 1 == FLASH_FRAMES) begin
                    n.done = 1; n.phase = 0; n.flash = 0;
                end else begin
                    n.flash = m.flash + 1;
                end
            end
        end
        n.busy = (n.phase != 0) ? 1 : 0;
        return n;
    endfunction

    // Reference model advance, mirroring the async reset of the meter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= mdl_reset();
            m_b <= mdl_reset();
        end else begin
            m_a <= mdl_step(m_a, 10, start, hit, ani_stb & animate, int'(ix), int'(iy));
            m_b <= mdl_step(m_b, 4, start, hit, ani_stb & animate, int'(ix), int'(iy));
        end
    end

    task automatic cmp(input string nm, input logic bs, input logic dn, input logic [7:0] sc,
                       input logic [3:0] zn, input logic [15:0] bx, input logic pe,
                       input logic [3:0] rr, input logic [3:0] gg, input logic [3:0] bb, input mdl_t m);
        n_tests++;
        if (bs !== 1'(m.busy) || dn !== 1'(m.done) || sc !== 8'(m.score) || zn !== 4'(m.zone) ||
            bx !== 16'(m.x) || pe !== 1'(m.pix) || rr !== 4'(m.r) || gg !== 4'(m.g) || bb !== 4'(m.b)) begin
            n_fail++;
            $display("FAIL %s t=%0t actual busy=%0d done=%0d score=%0d zone=%0d bar_x=%0d pix=%0d rgb=%h%h%h required busy=%0d done=%0d score=%0d zone=%0d bar_x=%0d pix=%0d rgb=%h%h%h",
                     nm, $time, bs, dn, sc, zn, bx, pe, rr, gg, bb,
                     m.busy, m.done, m.score, m.zone, m.x, m.pix, m.r[3:0], m.g[3:0], m.b[3:0]);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_v10", busy_a, done_a, score_a, zone_a, bx_a, pix_a, r_a, g_a, b_a, m_a);
            cmp("model_v4", busy_b, done_b, score_b, zone_b, bx_b, pix_b, r_b, g_b, b_b, m_b);
        end
    end

    task automatic lit(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit st, input bit ht, input bit tk, input int px, input int py);
        start = st; hit = ht; ani_stb = tk; animate = tk;
        ix = 16'(px); iy = 16'(py);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 0, 0);
    endtask

    task automatic check_reset_vals(input string nm);
        lit({nm, "_busy"}, int'(busy_a), 0);
        lit({nm, "_done"}, int'(done_a), 0);
        lit({nm, "_score"}, int'(score_a), 0);
        lit({nm, "_zone"}, int'(zone_a), 4);
        lit({nm, "_bar_x"}, int'(bx_a), 102);
        lit({nm, "_pix"}, int'(pix_a), 0);
    endtask

    task automatic do_reset(input string nm);
        start = 1'b0; hit = 1'b0; ani_stb = 1'b0; animate = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_vals(nm);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check_reset_vals("por");
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Near-centre hit: 22 ticks puts the bar at 322.
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        ticks(22);
        lit("t1_bar_x", int'(bx_a), 322);
        lit("t1_model_x", m_a.x, 322);
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        lit("t1_zone", int'(zone_a), 0);
        lit("t1_score", int'(score_a), 4);
        lit("t1_busy", int'(busy_a), 1);
        lit("t1_model_score", m_a.score, 4);
        ticks(29);
        lit("t1_done_early", int'(done_a), 0);
        ticks(1);
        lit("t1_done", int'(done_a), 1);
        lit("t1_busy_end", int'(busy_a), 0);
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        lit("t1_done_pulse", int'(done_a), 0);

        // Zone 2 hit at x=202 (d=118).
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        ticks(10);
        lit("t2_bar_x", int'(bx_a), 202);
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        lit("t2_zone", int'(zone_a), 2);
        lit("t2_score", int'(score_a), 2);
        lit("t2_model_zone", m_a.zone, 2);
        ticks(30);
        lit("t2_done", int'(done_a), 1);
        lit("t2_busy", int'(busy_a), 0);
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        lit("t2_done_pulse", int'(done_a), 0);
        lit("t2_score_hold", int'(score_a), 2);

        // Miss at the right limit.
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        lit("t3_score_clr", int'(score_a), 0);
        ticks(43);
        lit("t3_bar_x", int'(bx_a), 532);
        ticks(1);
        lit("t3_bar_stop", int'(bx_a), 532);
        lit("t3_score", int'(score_a), 0);
        lit("t3_zone", int'(zone_a), 4);
        lit("t3_busy", int'(busy_a), 1);
        ticks(30);
        lit("t3_done", int'(done_a), 1);
        do_reset("rst_a");

        // VELOCITY=4: zone-0 inclusive boundary, hit coinciding with a tick.
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        ticks(42);
        lit("t4_bar_x", int'(bx_b), 270);
        cyc(1'b0, 1'b1, 1'b1, 0, 0);
        lit("t4_latched_x", int'(bx_b), 270);
        lit("t4_zone", int'(zone_b), 0);
        lit("t4_score", int'(score_b), 4);
        lit("t4_model_zone", m_b.zone, 0);
        lit("t4_v10_zone_out", int'(zone_a), 4);
        lit("t4_v10_score_out", int'(score_a), 0);

        // Reset mid-flash, then no done afterwards.
        ticks(5);
        do_reset("rst_flash");
        ticks(40);
        lit("t5_busy", int'(busy_a), 0);

        // Start during a sweep is ignored.
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        ticks(5);
        cyc(1'b1, 1'b0, 1'b1, 0, 0);
        lit("t5_start_ignored", int'(bx_a), 162);
        do_reset("rst_sweep");

        // Pixel layer in IDLE, then the bar over zone 0.
        cyc(1'b0, 1'b0, 1'b0, 320, 300);
        lit("px_zone0_en", int'(pix_a), 1);
        lit("px_zone0_rgb", int'({r_a, g_a, b_a}), 12'h0F0);
        cyc(1'b0, 1'b0, 1'b0, 97, 300);
        lit("px_frame_en", int'(pix_a), 1);
        lit("px_frame_rgb", int'({r_a, g_a, b_a}), 12'hFFF);
        cyc(1'b0, 1'b0, 1'b0, 50, 300);
        lit("px_none_en", int'(pix_a), 0);
        lit("px_none_rgb", int'({r_a, g_a, b_a}), 0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        ticks(22);
        cyc(1'b0, 1'b0, 1'b0, 323, 300);
        lit("px_bar_rgb", int'({r_a, g_a, b_a}), 12'hFFF);
        do_reset("rst_px");

        // Random play, checked by the per-cycle model comparison.
        for (int i = 0; i < 5000; i++) begin
            start   = ($urandom_range(0, 49) == 0);
            hit     = ($urandom_range(0, 39) == 0);
            ani_stb = ($urandom_range(0, 1) == 0);
            animate = ($urandom_range(0, 2) != 0);
            ix      = 16'($urandom_range(80, 560));
            iy      = 16'($urandom_range(215, 395));
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fight_meter.md
Name: fight_meter

Overview:
Parametrised attack-timing meter for the FIGHT phase. It sweeps a moving bar across the fight box over N symmetric score zones and latches the bar position when the player hits. From that position it computes a zone index and a score, blinks the bar, then signals completion. It also emits a registered pixel layer (frame, zones, bar) that the VGA top ORs into vgaRed/Green/Blue.

Parameters:
FX, 100, left x of fight box interior
FY, 230, top y of fight box interior
F_WIDTH, 440, box interior width; centre CX = FX + F_WIDTH/2
F_HEIGHT, 150, box interior height
BORDER, 5, frame thickness drawn outside interior
BAR_R, 2, moving bar half-width
VELOCITY, 10, bar x increment per animate tick
NUM_ZONES, 4, score zones, legal 1..8
ZONE_STEP, 50, zone k covers |x-CX| <= (k+1)*ZONE_STEP
ZONE_TAPER, 20, zone k column inset k*ZONE_TAPER from top and from bottom
FLASH_FRAMES, 30, animate ticks spent blinking after hit/miss

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset; asynchronous, active-low
i_ani_stb  in  1  pixel strobe
i_animate  in  1  end-of-frame flag; advance tick = i_ani_stb & i_animate
i_start  in  1  one-cycle start request
i_hit  in  1  one-cycle player hit (debounced upstream)
i_x  in  16  current VGA x
i_y  in  16  current VGA y
o_busy  out  1  high in SWEEP or FLASH
o_done  out  1  one-cycle pulse at end of FLASH
o_score  out  8  NUM_ZONES-zone on hit; 0 on miss
o_zone  out  4  latched zone index; NUM_ZONES means outside/miss
o_bar_x  out  16  bar centre x
o_pix_en  out  1  pixel belongs to this layer
o_red, o_green, o_blue  out  4 each  layer colour

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_bar_x=FX+BAR_R; o_score=0; o_zone=NUM_ZONES; o_busy=0; o_done=0; pixel outputs 0; flash counter 0. Reset mid-sweep or mid-flash aborts with no o_done.
- IDLE: bar hidden. i_start -> SWEEP next cycle, o_bar_x=FX+BAR_R. i_start is ignored in any other state. i_hit is ignored outside SWEEP.
- SWEEP: on each advance tick, o_bar_x += VELOCITY.
- Miss: if o_bar_x+VELOCITY > FX+F_WIDTH-BAR_R at an advance tick, the bar does not move; o_score=0, o_zone=NUM_ZONES, go to FLASH.
- Hit: i_hit in SWEEP latches the current o_bar_x, using the pre-advance value when it coincides with a tick. Compute d=|o_bar_x-CX| as a 16-bit unsigned value. Zone = smallest k with d <= (k+1)*ZONE_STEP; if none, zone=NUM_ZONES and score=0. Go to FLASH. Hit wins over a simultaneous miss.
- Score/zone registers become valid on the cycle FLASH is entered and hold until the next i_start.
- FLASH: the counter increments per advance tick. The bar is visible when counter bit 2 is 0. At counter==FLASH_FRAMES-1 plus a tick: o_done=1 for one cycle, go to IDLE, bar hidden.
- Pixel layer is registered, with 1-cycle latency from i_x/i_y. Priority, highest first:
  - bar, white F/F/F: |i_x-o_bar_x| <= BAR_R, FY <= i_y <= FY+F_HEIGHT, visible in SWEEP or in blink-on FLASH.
  - frame, white: inside the BORDER-expanded box but not inside the interior.
  - zone k column: d_pix=|i_x-CX| in ((k)*ZONE_STEP, (k+1)*ZONE_STEP], or [0, ZONE_STEP] for k=0; y inset by k*ZONE_TAPER. Colours: k=0 green 0/F/0, k=1 yellow F/F/0, k=2 orange F/A/0, k>=3 blue 8/C/F.
  - otherwise o_pix_en=0 and colour 0.
- All comparisons are 16-bit unsigned. Subtractions use the larger operand first, so there is no wrap.

Optional Feature:
FIGHT_METER_BOUNCE_EN. When defined, reaching the right limit reverses direction: o_bar_x -= VELOCITY per tick. A miss occurs only when o_bar_x-VELOCITY < FX+BAR_R, and only one return pass is allowed. Hit scoring is unchanged. When undefined, the right limit is an immediate miss as above.

Test Plan:
- Reset default params, i_start, 22 advance ticks (x=322), i_hit -> d=2, o_zone=0, o_score=4, o_busy=1.
- i_start, 10 ticks (x=202), i_hit -> d=118, o_zone=2, o_score=2; after 30 more ticks o_done single pulse, o_busy=0.
- i_start, no hit, feature off -> x stops at 532; 44th tick gives o_score=0, o_zone=4; FLASH then o_done.
- VELOCITY=4, 42 ticks (x=270, d=50), i_hit -> zone 0 boundary inclusive, score 4; i_hit on same cycle as tick 43 latches 270.
- i_rst_n low mid-FLASH -> all outputs at reset values immediately, no o_done; i_start during SWEEP ignored.
- Pixel check: i_x=320, i_y=300 in IDLE -> next cycle o_pix_en=1, 0/F/0; i_x=97, i_y=300 -> white frame; i_x=50 -> o_pix_en=0.
